// File: rtl/smem_output_writer.sv
// smem_output_writer: sink for the SMEM result-queue output stage.
// Buffers result beats in a first-word-fall-through FIFO, throttles the producer
// with a registered almost-full stall, and drains beats to a host write channel
// at consecutive 64-byte line addresses.
module smem_output_writer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [63:0]  base_addr,
    input  logic         output_request,
    output logic         output_permit,
    input  logic [511:0] output_data,
    input  logic         output_valid,
    input  logic         output_finish,
    output logic         stall,
    output logic         wr_valid,
    output logic [63:0]  wr_addr,
    output logic [511:0] wr_data,
    input  logic         wr_ready,
    output logic [31:0]  line_count,
    output logic         done,
    output logic         overflow_err
);

    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned DATA_W     = 512;
    localparam int unsigned LCNT_W     = 32;
    localparam int unsigned LINE_BYTES = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    w_rd_ptr_next;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_after_pop;
    logic [CNT_W-1:0]    w_count_next;
    logic [DATA_W-1:0]   w_head_next;

    logic                r_permit;
    logic                r_stall;
    logic                r_done;
    logic                r_wr_valid;
    logic                r_ovf;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [LCNT_W-1:0]   r_line_count;

    logic                w_start_acc;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_permit_next;
    logic                w_stall_next;
    logic                w_done_next;

    assign output_permit = r_permit;
    assign stall         = r_stall;
    assign done          = r_done;
    assign wr_valid      = r_wr_valid;
    assign wr_addr       = r_addr;
    assign wr_data       = r_wr_data;
    assign line_count    = r_line_count;
    assign overflow_err  = r_ovf;

    // FIFO bookkeeping: push/pop qualification and post-update occupancy/head
    always_comb begin
        w_start_acc       = start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_full            = (r_count == CNT_W'(FIFO_DEPTH));
        w_pop             = r_wr_valid && wr_ready;
        w_push            = (r_state == S_STREAM) && output_valid && (!w_full || w_pop);
        w_drop            = (r_state == S_STREAM) && output_valid && w_full && !w_pop;
        w_count_after_pop = r_count - CNT_W'(w_pop);
        w_count_next      = w_count_after_pop + CNT_W'(w_push);
        w_rd_ptr_next     = r_rd_ptr + PTR_W'(w_pop);
        // An empty FIFO after the pop means the incoming beat becomes the head
        w_head_next       = (w_count_after_pop == '0) ? output_data : r_mem[w_rd_ptr_next];
    end

    // Next-state and next registered-output decode
    always_comb begin
        w_state_next  = r_state;
        w_permit_next = 1'b0;
        w_stall_next  = 1'b0;
        w_done_next   = 1'b0;
        case (r_state)
            S_IDLE:     if (start)                w_state_next = S_WAIT_REQ;
            S_WAIT_REQ: if (output_request)       w_state_next = S_STREAM;
            S_STREAM:   if (output_finish)        w_state_next = S_FLUSH;
            S_FLUSH:    if (r_count == '0)        w_state_next = S_DONE;
            S_DONE:     if (start)                w_state_next = S_WAIT_REQ;
            default:                              w_state_next = S_IDLE;
        endcase
        w_permit_next = (w_state_next == S_STREAM) || (w_state_next == S_FLUSH);
        w_done_next   = (w_state_next == S_DONE);
        w_stall_next  = (w_state_next != S_IDLE) && (w_state_next != S_DONE) &&
                        (w_count_next >= CNT_W'(AF_LEVEL));
    end

    // State and control-output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_permit <= 1'b0;
            r_stall  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_permit <= w_permit_next;
            r_stall  <= w_stall_next;
            r_done   <= w_done_next;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= output_data;
        end
    end

    // FIFO pointers, head register, write address and batch counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_wr_valid   <= 1'b0;
            r_wr_data    <= '0;
            r_addr       <= '0;
            r_line_count <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_wr_valid <= (w_count_next != '0);
            if (w_count_next != '0) begin
                r_wr_data <= w_head_next;
            end
            if (w_start_acc) begin
                r_addr       <= base_addr;
                r_line_count <= '0;
                r_ovf        <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_addr       <= r_addr + ADDR_W'(LINE_BYTES);
                    r_line_count <= r_line_count + LCNT_W'(1);
                end
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

endmodule
